// File: rtl/mem_rd_arbiter_pkg.sv
// Shared encodings for the I-cache / D-cache read arbiter.
// Covers the FSM states, the owner encoding and the address width.
package mem_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ISSU = 2'b01,
        ARB_WAIT = 2'b10
    } arb_state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    localparam int ADDR_W = 32;

endpackage

// File: rtl/mem_rd_arbiter_rd_req_capture.sv
// Per-requester capture: holds one pending read request and its line address.
// A pulse is rejected as a duplicate while one is already pending or owns the bus.
module rd_req_capture
    import mem_rd_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              start_rq,
    input  logic [ADDR_W-1:0] addr,
    input  logic              owns,
    input  logic              grant,
    output logic              pend,
    output logic [ADDR_W-1:0] addr_q,
    output logic              dup_err
);

    assign dup_err = start_rq & (pend | owns);

    // Flush wins over a same-cycle pulse so a flushed request never reaches the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= 1'b0;
            addr_q <= '0;
        end else if (flush) begin
            pend <= 1'b0;
        end else if (start_rq && !dup_err) begin
            pend   <= 1'b1;
            addr_q <= addr;
        end else if (grant) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master between I-cache and D-cache refills.
// Issues a single read at a time and steers data/finish back to the owning requester.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter bit DC_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_pipe,
    input  logic              icr_start_rq,
    input  logic [ADDR_W-1:0] ic_rin_addr,
    output logic              ic_rdat_m_valid,
    output logic              ic_finish_mrd,
    input  logic              dcr_start_rq,
    input  logic [ADDR_W-1:0] dc_rin_addr,
    output logic              dc_rdat_m_valid,
    output logic              dc_finish_mrd,
    output logic              rd_start_rq,
    output logic [ADDR_W-1:0] rd_rin_addr,
    input  logic              rdat_m_valid,
    input  logic              finish_mrd,
    output logic              rd_owner_dc,
    output logic              arb_err
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              rr_q;
    logic              ic_drop_q;
    logic              busy;
    logic              grant;
    logic              grant_dc;
    logic              xfer_done;
    logic              ic_pend;
    logic              dc_pend;
    logic              ic_pend_eff;
    logic [ADDR_W-1:0] ic_addr_q;
    logic [ADDR_W-1:0] dc_addr_q;
    logic              ic_dup;
    logic              dc_dup;
    logic              ic_owns;
    logic              dc_owns;
    logic              stray;
    logic              ic_block;

    assign busy        = (state_q != ARB_IDLE);
    assign ic_owns     = busy & (rd_owner_dc == OWN_IC);
    assign dc_owns     = busy & (rd_owner_dc == OWN_DC);
    assign ic_pend_eff = ic_pend & ~rst_pipe;
    // rr_q=1 gives DC priority when both requesters are pending.
    assign grant_dc    = dc_pend & (~ic_pend_eff | rr_q);
    assign stray       = ~busy & (rdat_m_valid | finish_mrd);

    rd_req_capture u_ic_cap (
        .clk      (clk),
        .rst      (rst),
        .flush    (rst_pipe),
        .start_rq (icr_start_rq),
        .addr     (ic_rin_addr),
        .owns     (ic_owns),
        .grant    (grant & ~grant_dc),
        .pend     (ic_pend),
        .addr_q   (ic_addr_q),
        .dup_err  (ic_dup)
    );

    rd_req_capture u_dc_cap (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .start_rq (dcr_start_rq),
        .addr     (dc_rin_addr),
        .owns     (dc_owns),
        .grant    (grant & grant_dc),
        .pend     (dc_pend),
        .addr_q   (dc_addr_q),
        .dup_err  (dc_dup)
    );

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        rd_start_rq = 1'b0;
        xfer_done   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (ic_pend_eff || dc_pend) begin
                    grant   = 1'b1;
                    state_d = ARB_ISSU;
                end
            end
            ARB_ISSU: begin
                rd_start_rq = 1'b1;
                xfer_done   = finish_mrd;
                state_d     = finish_mrd ? ARB_IDLE : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (finish_mrd) begin
                    xfer_done = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_q        <= DC_FIRST;
            rd_owner_dc <= OWN_IC;
            ic_drop_q   <= 1'b0;
            rd_rin_addr <= '0;
            arb_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rd_owner_dc <= grant_dc ? OWN_DC : OWN_IC;
                rd_rin_addr <= grant_dc ? dc_addr_q : ic_addr_q;
            end
            if (xfer_done) begin
                rr_q      <= ~rd_owner_dc;
                ic_drop_q <= 1'b0;
            end else if (ic_owns && rst_pipe) begin
                ic_drop_q <= 1'b1;
            end
            if (ic_dup || dc_dup || stray) begin
                arb_err <= 1'b1;
            end
        end
    end

    // The flush cycle itself is also blocked so no beat leaks before ic_drop_q registers.
    assign ic_block        = ic_drop_q | rst_pipe;
    assign ic_rdat_m_valid = ic_owns & rdat_m_valid & ~ic_block;
    assign ic_finish_mrd   = ic_owns & finish_mrd & ~ic_block;
    assign dc_rdat_m_valid = dc_owns & rdat_m_valid;
    assign dc_finish_mrd   = dc_owns & finish_mrd;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: per-cycle vector table plus a fairness sequence.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_mem_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_pipe = 1'b0;
    logic        icr_start_rq = 1'b0;
    logic [31:0] ic_rin_addr = '0;
    logic        ic_rdat_m_valid;
    logic        ic_finish_mrd;
    logic        dcr_start_rq = 1'b0;
    logic [31:0] dc_rin_addr = '0;
    logic        dc_rdat_m_valid;
    logic        dc_finish_mrd;
    logic        rd_start_rq;
    logic [31:0] rd_rin_addr;
    logic        rdat_m_valid = 1'b0;
    logic        finish_mrd = 1'b0;
    logic        rd_owner_dc;
    logic        arb_err;

    int n_cmp = 0;
    int n_err = 0;
    int cur_test = 0;

    typedef struct {
        int          test;
        logic        rst_first;
        logic        rp;
        logic        icr;
        logic [31:0] ica;
        logic        dcr;
        logic [31:0] dca;
        logic        rv;
        logic        fin;
        logic        st;
        logic [31:0] addr;
        logic        icv;
        logic        icf;
        logic        dcv;
        logic        dcf;
        logic        own;
        logic        err;
    } vec_t;

    vec_t tab[$];
    logic [0:0] exp_q[$];

    mem_rd_arbiter #(.DC_FIRST(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .rst_pipe        (rst_pipe),
        .icr_start_rq    (icr_start_rq),
        .ic_rin_addr     (ic_rin_addr),
        .ic_rdat_m_valid (ic_rdat_m_valid),
        .ic_finish_mrd   (ic_finish_mrd),
        .dcr_start_rq    (dcr_start_rq),
        .dc_rin_addr     (dc_rin_addr),
        .dc_rdat_m_valid (dc_rdat_m_valid),
        .dc_finish_mrd   (dc_finish_mrd),
        .rd_start_rq     (rd_start_rq),
        .rd_rin_addr     (rd_rin_addr),
        .rdat_m_valid    (rdat_m_valid),
        .finish_mrd      (finish_mrd),
        .rd_owner_dc     (rd_owner_dc),
        .arb_err         (arb_err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        rst_pipe     = 1'b0;
        icr_start_rq = 1'b0;
        dcr_start_rq = 1'b0;
        rdat_m_valid = 1'b0;
        finish_mrd   = 1'b0;
    endtask

    // Driver: one clock cycle of inputs, returning at the falling edge for sampling.
    task automatic drive(input logic rp, icr, input logic [31:0] ica, input logic dcr,
                         input logic [31:0] dca, input logic rv, fin);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        rst_pipe     = rp;
        icr_start_rq = icr;
        ic_rin_addr  = ica;
        dcr_start_rq = dcr;
        dc_rin_addr  = dca;
        rdat_m_valid = rv;
        finish_mrd   = fin;
        @(negedge clk);
    endtask

    task automatic add(input logic r, rp, icr, input logic [31:0] ica, input logic dcr,
                       input logic [31:0] dca, input logic rv, fin, input logic st,
                       input logic [31:0] a, input logic icv, icf, dcv, dcf, own, err);
        vec_t v;
        v.test = cur_test; v.rst_first = r; v.rp = rp; v.icr = icr; v.ica = ica;
        v.dcr = dcr; v.dca = dca; v.rv = rv; v.fin = fin; v.st = st; v.addr = a;
        v.icv = icv; v.icf = icf; v.dcv = dcv; v.dcf = dcf; v.own = own; v.err = err;
        tab.push_back(v);
    endtask

    // Scoreboard helpers
    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [38:0] got;
        logic [38:0] exp;
        got = {rd_start_rq, rd_rin_addr, ic_rdat_m_valid, ic_finish_mrd,
               dc_rdat_m_valid, dc_finish_mrd, rd_owner_dc, arb_err};
        exp = {v.st, v.addr, v.icv, v.icf, v.dcv, v.dcf, v.own, v.err};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL vec %0d (test %0d) {start,addr,icv,icf,dcv,dcf,own,err}: got %h expected %h",
                     idx, v.test, got, exp);
        end
    endtask

    initial begin
        // Test 1: IC alone, uncontested.
        cur_test = 1;
        add(1,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,1,32'h1230,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 1,32'h1230,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h1230,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,1,0, 0,32'h1230,1,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,1, 0,32'h1230,0,1,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h1230,0,0,0,0,0,0);
        // Test 2: simultaneous requests, DC first, data+finish in one beat.
        cur_test = 2;
        add(1,0,1,32'h100,1,32'h8000_0200,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 1,32'h8000_0200,0,0,0,0,1,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h8000_0200,0,0,0,0,1,0);
        add(0,0,0,32'h0,0,32'h0,1,1, 0,32'h8000_0200,0,0,1,1,1,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h8000_0200,0,0,0,0,1,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 1,32'h100,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,1, 0,32'h100,0,1,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h100,0,0,0,0,0,0);
        // Test 4: flush during IC WAIT, DC queued behind it.
        cur_test = 4;
        add(1,0,1,32'h2000,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 1,32'h2000,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,1,0, 0,32'h2000,1,0,0,0,0,0);
        add(0,1,0,32'h0,1,32'h4440,0,0, 0,32'h2000,0,0,0,0,0,0);
        for (int k = 0; k < 4; k++)
            add(0,0,0,32'h0,0,32'h0,1,0, 0,32'h2000,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,1, 0,32'h2000,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h2000,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 1,32'h4440,0,0,0,0,1,0);
        add(0,0,0,32'h0,0,32'h0,0,1, 0,32'h4440,0,0,0,1,1,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h4440,0,0,0,0,1,0);
        // Test 5: IC pulse in the flush cycle is dropped; a later IC read works.
        cur_test = 5;
        add(1,1,1,32'h3000,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,1,32'h3300,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 1,32'h3300,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,1,1, 0,32'h3300,1,1,0,0,0,0);
        // Test 6a: duplicate IC pulse while IC owns the bus.
        cur_test = 6;
        add(1,0,1,32'h10,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 1,32'h10,0,0,0,0,0,0);
        add(0,0,1,32'h20,0,32'h0,0,0, 0,32'h10,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h10,0,0,0,0,0,1);
        add(0,0,0,32'h0,0,32'h0,0,1, 0,32'h10,0,1,0,0,0,1);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h10,0,0,0,0,0,1);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h10,0,0,0,0,0,1);
        // Test 6b: reset clears everything; stray data beat in IDLE.
        cur_test = 7;
        add(1,0,0,32'h0,0,32'h0,1,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,1);
        add(0,0,0,32'h0,0,32'h0,0,1, 0,32'h0,0,0,0,0,0,1);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,1);
        // Reset after an error returns all outputs to 0.
        cur_test = 8;
        add(1,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);
        add(0,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0,0,0,0);

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].rst_first) do_reset();
            drive(tab[i].rp, tab[i].icr, tab[i].ica, tab[i].dcr, tab[i].dca, tab[i].rv, tab[i].fin);
            check_vec(i, tab[i]);
        end

        // Test 3: fairness, each finished owner re-requests immediately.
        begin
            logic [31:0] ic_a;
            logic [31:0] dc_a;
            logic [0:0]  exp_own;
            logic        found;
            ic_a = 32'h0000_1000;
            dc_a = 32'h8000_1000;
            for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 1'b1 : 1'b0);
            do_reset();
            drive(0, 1, ic_a, 1, dc_a, 0, 0);
            for (int k = 0; k < 6; k++) begin
                found = 1'b0;
                for (int t = 0; t < 8 && !found; t++) begin
                    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
                    if (rd_start_rq) found = 1'b1;
                end
                exp_own = exp_q.pop_front();
                if (!found) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL fair_timeout grant %0d: got no rd_start_rq expected one within 8 cycles", k);
                    break;
                end
                check1($sformatf("fair_owner grant %0d", k), {31'h0, rd_owner_dc}, {31'h0, exp_own});
                check1($sformatf("fair_addr grant %0d", k), rd_rin_addr, exp_own[0] ? dc_a : ic_a);
                drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
                drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
                if (exp_own[0]) begin
                    dc_a = dc_a + 32'h40;
                    drive(0, 0, 32'h0, 1, dc_a, 0, 0);
                end else begin
                    ic_a = ic_a + 32'h40;
                    drive(0, 1, ic_a, 0, 32'h0, 0, 0);
                end
            end
            check1("fair_arb_err", {31'h0, arb_err}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
